// File: rtl/demux_seq_pkg.sv
// demux_seq_pkg: shared constants and FSM encoding for the 1:8 demux sequencer.
package demux_seq_pkg;
   localparam int NUM_CH = 8;
   localparam int SEL_W = 3;
   localparam int HOLD_MAX = 16;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/demux_hold_timer.sv
// demux_hold_timer: counts cycles a channel is held; last marks the final hold cycle.
module demux_hold_timer
   import demux_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic last
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
      $error("demux_hold_timer: HOLD_CYCLES must be 1..16");
   end
   logic [CW-1:0] cnt;
   assign last = en && (cnt == LAST_CNT);
   // Cleared while idle, so every channel starts its hold from zero.
   always_ff @(posedge clk) begin
      if (rst || !en || last) cnt <= '0;
      else cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/demux1_8_seq_driver.sv
// demux1_8_seq_driver: serialises an accepted byte onto demux select/data lines,
// one channel per HOLD_CYCLES, followed by a one-cycle done pulse.
module demux1_8_seq_driver
   import demux_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       S3,
   output logic       S2,
   output logic       S1,
   output logic       A,
   output logic       strobe,
   output logic       busy,
   output logic       done
);
   state_t state, state_n;
   logic [SEL_W-1:0] idx, idx_n;
   logic [NUM_CH-1:0] data, data_n;
   logic last;
   demux_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (state == ST_SEND),
      .last (last)
   );
   always_comb begin
      state_n = state;
      idx_n = idx;
      data_n = data;
      case (state)
         ST_IDLE: if (din_valid) begin
            data_n = din;
            idx_n = '0;
            state_n = ST_SEND;
         end
         ST_SEND: if (last) begin
            if (idx == SEL_W'(NUM_CH - 1)) state_n = ST_DONE;
            else idx_n = idx + 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end
   // Outputs are decoded from next-state values so they register alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx <= '0;
         data <= '0;
         din_ready <= 1'b1;
         {S3, S2, S1} <= '0;
         A <= 1'b0;
         strobe <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         data <= data_n;
         din_ready <= state_n == ST_IDLE;
         {S3, S2, S1} <= state_n == ST_SEND ? idx_n : '0;
         A <= state_n == ST_SEND && data_n[idx_n];
         strobe <= state_n == ST_SEND;
         busy <= state_n != ST_IDLE;
         done <= state_n == ST_DONE;
      end
   end
endmodule

// File: tb/tb_demux1_8_seq_driver.sv
// tb_demux1_8_seq_driver: directed checks of the sequencer with HOLD_CYCLES=1 and 3.
module tb_demux1_8_seq_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst1, v1, rdy1, s3_1, s2_1, s1_1, a1, stb1, busy1, done1;
   logic rst3, v3, rdy3, s3_3, s2_3, s1_3, a3, stb3, busy3, done3;
   logic [7:0] din1, din3, st1, st3;
   int vectors = 0;
   int miscompares = 0;
   demux1_8_seq_driver #(.HOLD_CYCLES(1)) u1 (
      .clk(clk), .rst(rst1), .din(din1), .din_valid(v1), .din_ready(rdy1),
      .S3(s3_1), .S2(s2_1), .S1(s1_1), .A(a1), .strobe(stb1), .busy(busy1), .done(done1)
   );
   demux1_8_seq_driver #(.HOLD_CYCLES(3)) u3 (
      .clk(clk), .rst(rst3), .din(din3), .din_valid(v3), .din_ready(rdy3),
      .S3(s3_3), .S2(s2_3), .S1(s1_3), .A(a3), .strobe(stb3), .busy(busy3), .done(done3)
   );
   // Packed view: {din_ready, S3, S2, S1, A, strobe, busy, done}
   assign st1 = {rdy1, s3_1, s2_1, s1_1, a1, stb1, busy1, done1};
   assign st3 = {rdy3, s3_3, s2_3, s1_3, a3, stb3, busy3, done3};
   localparam logic [7:0] IDLE_V = 8'b1_000_0_0_0_0;
   localparam logic [7:0] DONE_V = 8'b0_000_0_0_1_1;
   function automatic logic [7:0] send_v(int ch, logic a);
      logic [2:0] s;
      s = 3'(ch);
      return {1'b0, s, a, 1'b1, 1'b1, 1'b0};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask
   initial begin
      logic [7:0] pat;
      rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0; din1 = '0; din3 = '0;
      tick(); tick();
      chk("reset_h1", st1, IDLE_V);
      chk("reset_h3", st3, IDLE_V);
      rst1 = 1'b0; rst3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle", st1, IDLE_V);
      end
      // HOLD=1, 0xA5: A pattern 1,0,1,0,0,1,0,1 on channels 0..7
      pat = 8'b1010_0101;
      din1 = 8'hA5; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a5_ch%0d", i), st1, send_v(i, pat[i]));
         tick();
      end
      chk("a5_done", st1, DONE_V);
      tick();
      chk("a5_ready", st1, IDLE_V);
      // HOLD=3, 0x81: 3 cycles A=1, 18 cycles A=0, 3 cycles A=1
      din3 = 8'h81; v3 = 1'b1;
      tick();
      v3 = 1'b0;
      for (int c = 0; c < 24; c++) begin
         chk($sformatf("h3_c%0d", c), st3, send_v(c / 3, c < 3 || c >= 21));
         tick();
      end
      chk("h3_done", st3, DONE_V);
      tick();
      chk("h3_idle", st3, IDLE_V);
      tick();
      chk("h3_idle2", st3, IDLE_V);
      // Back-to-back, valid held high; din switches to 0x00 during the 0xFF word
      din1 = 8'hFF; v1 = 1'b1;
      tick();
      din1 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ff_ch%0d", i), st1, send_v(i, 1'b1));
         tick();
      end
      chk("ff_done", st1, DONE_V);
      tick();
      chk("b2b_gap", st1, IDLE_V);
      tick();
      v1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("zero_ch%0d", i), st1, send_v(i, 1'b0));
         tick();
      end
      chk("zero_done", st1, DONE_V);
      tick();
      chk("zero_idle", st1, IDLE_V);
      // Reset while channel 4 is on the lines
      din1 = 8'h3C; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick(); tick(); tick(); tick();
      chk("mid_ch4", st1, send_v(4, 1'b1));
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      chk("mid_rst", st1, IDLE_V);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mid_no_done", st1, IDLE_V);
      end
      // Reset and valid on the same edge: reset wins
      din1 = 8'h5A; v1 = 1'b1; rst1 = 1'b1;
      tick();
      rst1 = 1'b0; v1 = 1'b0;
      chk("rv_reset", st1, IDLE_V);
      tick();
      chk("rv_nocap", st1, IDLE_V);
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      chk("rv_ch0", st1, send_v(0, 1'b0));
      tick();
      chk("rv_ch1", st1, send_v(1, 1'b1));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
